// File: rtl/ram_dual_port_pipelined_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types and helpers for the dual-port pipelined RAM.
//   rdw_mode_e  : mixed-port read-during-write behaviour
//                 (RDW_OLD = pre-write word, RDW_NEW = forwarded write data)
//   byte_merge  : lane-wise merge of a new word into an old word under a
//                 byte-enable mask
// Operands are carried at MAX_W bits so one helper serves every instance
// width. Callers zero-extend into it and truncate the result back.
// ---------------------------------------------------------------------------
package ram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  // Upper bound on WIDTH (and thus on the number of byte lanes).
  localparam int MAX_W = 1024;

  // Bit b takes new_w[b] when the lane holding it (b / byte_w) is enabled.
  // Lanes beyond the caller's NBE see be=0 and keep old_w.
  function automatic logic [MAX_W-1:0] byte_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_W-1:0] be,
    input int               byte_w = 8
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int b = 0; b < MAX_W; b++) begin
      if (be[b / byte_w]) r[b] = new_w[b];
    end
    return r;
  endfunction

endpackage : ram_pkg

// File: rtl/ram_dual_port_pipelined_if.sv
// ---------------------------------------------------------------------------
// ram_dual_port_pipelined_if
// Bus bundle for the two RAM ports.
//   addr_x  : word address (out-of-range addresses are legal, see top)
//   data_x  : write data
//   wren_x  : write request
//   be_x    : byte-lane enables for writes
//   rden_x  : read request
//   q_x     : read data (holds last valid value)
//   qv_x    : read data valid, one pulse per read
// master = the user of the RAM, slave = the RAM itself.
// ---------------------------------------------------------------------------
interface ram_dual_port_pipelined_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int NBE    = 4
);

  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [WIDTH-1:0]  data_a;
  logic [WIDTH-1:0]  data_b;
  logic              wren_a;
  logic              wren_b;
  logic [NBE-1:0]    be_a;
  logic [NBE-1:0]    be_b;
  logic              rden_a;
  logic              rden_b;
  logic [WIDTH-1:0]  q_a;
  logic [WIDTH-1:0]  q_b;
  logic              qv_a;
  logic              qv_b;

  modport master (
    output addr_a, addr_b, data_a, data_b, wren_a, wren_b,
           be_a, be_b, rden_a, rden_b,
    input  q_a, q_b, qv_a, qv_b
  );

  modport slave (
    input  addr_a, addr_b, data_a, data_b, wren_a, wren_b,
           be_a, be_b, rden_a, rden_b,
    output q_a, q_b, qv_a, qv_b
  );

endinterface : ram_dual_port_pipelined_if

// File: rtl/ram_dual_port_pipelined_read_pipe.sv
// ---------------------------------------------------------------------------
// ram_read_pipe
// Read-side shift register carrying data and valid together.
//   clk, rst : clock and synchronous active-high reset (works with clken=0)
//   clken    : stage advance enable; 0 freezes every stage
//   vld_in   : read issued this cycle
//   d        : word read from the array (already forwarded)
//   q, qv    : last stage data and valid
// Stage 0 is the array read register; stages 1..LATENCY-1 are output
// stages. A stage only loads data when the valid entering it is set, so
// q keeps the last valid word while qv is low.
// ---------------------------------------------------------------------------
module ram_read_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clken,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  logic [WIDTH-1:0]   data_p [LATENCY];
  logic [LATENCY-1:0] vld_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      // In-flight reads are dropped and the output word clears with them.
      vld_p <= '0;
      for (int i = 0; i < LATENCY; i++) data_p[i] <= '0;
    end else if (clken) begin
      // Stage 0: array read register
      vld_p[0] <= vld_in;
      if (vld_in) data_p[0] <= d;
      // Stages 1..LATENCY-1: output stages
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign q  = data_p[LATENCY-1];
  assign qv = vld_p[LATENCY-1];

endmodule : ram_read_pipe

// File: rtl/ram_dual_port_pipelined.sv
// ---------------------------------------------------------------------------
// ram_dual_port_pipelined
// Inferred true dual-port RAM with per-port byte enables, a read-valid
// pipeline of LATENCY enabled cycles and a global clock enable.
//   clk   : clock
//   rst   : synchronous active-high reset of the read pipelines (q/qv);
//           memory contents are not reset
//   clken : global enable; 0 freezes all registers and blocks writes
//   bus   : slave side of ram_dual_port_pipelined_if (ports A and B)
// Behaviour notes:
//   - Dual write to one address: both ports' lanes land, B wins overlaps.
//   - Same-port read-during-write returns the lane-merged new word.
//   - Mixed-port read-during-write follows RDW_MIXED.
//   - Addresses >= DEPTH: writes dropped, reads return 0 (still valid).
// ---------------------------------------------------------------------------
module ram_dual_port_pipelined
  import ram_pkg::*;
#(
  parameter int        WIDTH     = 32,
  parameter int        DEPTH     = 256,
  parameter int        ADDR_W    = $clog2(DEPTH),
  parameter int        BYTE_W    = 8,
  parameter int        LATENCY   = 2,
  parameter rdw_mode_e RDW_MIXED = RDW_OLD,
  parameter int        INIT_ZERO = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clken,
  ram_dual_port_pipelined_if.slave bus
);

  localparam int NBE = WIDTH / BYTE_W;

  // Declaration initialiser gives known contents in simulation and an
  // init image in synthesis; INIT_ZERO=0 leaves contents undefined.
  logic [WIDTH-1:0] mem [DEPTH] =
    '{default: ((INIT_ZERO != 0) ? {WIDTH{1'b0}} : {WIDTH{1'bx}})};

  logic             en;
  logic             in_range_a;
  logic             in_range_b;
  logic             we_a;
  logic             we_b;
  logic             same_addr;
  logic             both_wr_same;
  logic [WIDTH-1:0] wr_word_a;
  logic [WIDTH-1:0] wr_word_b;
  logic [WIDTH-1:0] rd_word_a;
  logic [WIDTH-1:0] rd_word_b;
  logic [WIDTH-1:0] q_a_w;
  logic [WIDTH-1:0] q_b_w;
  logic             qv_a_w;
  logic             qv_b_w;

  function automatic logic [WIDTH-1:0] merge(
    input logic [WIDTH-1:0] old_w,
    input logic [WIDTH-1:0] new_w,
    input logic [NBE-1:0]   be
  );
    return WIDTH'(byte_merge(MAX_W'(old_w), MAX_W'(new_w), MAX_W'(be), BYTE_W));
  endfunction

  // Resolve what a port reads when the address it reads is being written
  // this cycle. Lanes are applied A first, then B, so that when both ports
  // contribute the result matches the B-priority write.
  function automatic logic [WIDTH-1:0] read_word(
    input logic [WIDTH-1:0] base,
    input logic             inc_a,
    input logic             inc_b
  );
    logic [WIDTH-1:0] w;
    w = base;
    if (inc_a) w = merge(w, bus.data_a, bus.be_a);
    if (inc_b) w = merge(w, bus.data_b, bus.be_b);
    return w;
  endfunction

  assign en           = clken & ~rst;
  assign in_range_a   = (int'(bus.addr_a) < DEPTH);
  assign in_range_b   = (int'(bus.addr_b) < DEPTH);
  assign we_a         = en & bus.wren_a & in_range_a;
  assign we_b         = en & bus.wren_b & in_range_b;
  assign same_addr    = (bus.addr_a == bus.addr_b);
  assign both_wr_same = we_a & we_b & same_addr;

  // B's word is built on top of A's when both hit one address, so
  // non-overlapping A lanes survive and overlapping lanes go to B.
  always_comb begin
    wr_word_a = '0;
    wr_word_b = '0;
    if (we_a) wr_word_a = merge(mem[bus.addr_a], bus.data_a, bus.be_a);
    if (we_b) begin
      if (both_wr_same) wr_word_b = merge(wr_word_a, bus.data_b, bus.be_b);
      else              wr_word_b = merge(mem[bus.addr_b], bus.data_b, bus.be_b);
    end
  end

  always_ff @(posedge clk) begin
    if (we_a && !both_wr_same) mem[bus.addr_a] <= wr_word_a;
    if (we_b)                  mem[bus.addr_b] <= wr_word_b;
  end

  // Own-port writes always forward; the other port's only in RDW_NEW.
  // Out-of-range reads return zero, and no forwarding can match them
  // because out-of-range writes never assert we_x.
  always_comb begin
    rd_word_a = '0;
    rd_word_b = '0;
    if (in_range_a) begin
      rd_word_a = read_word(mem[bus.addr_a], we_a,
                            (RDW_MIXED == RDW_NEW) && we_b && same_addr);
    end
    if (in_range_b) begin
      rd_word_b = read_word(mem[bus.addr_b],
                            (RDW_MIXED == RDW_NEW) && we_a && same_addr, we_b);
    end
  end

  ram_read_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe_a (
    .clk    (clk),
    .rst    (rst),
    .clken  (clken),
    .vld_in (bus.rden_a),
    .d      (rd_word_a),
    .q      (q_a_w),
    .qv     (qv_a_w)
  );

  ram_read_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe_b (
    .clk    (clk),
    .rst    (rst),
    .clken  (clken),
    .vld_in (bus.rden_b),
    .d      (rd_word_b),
    .q      (q_b_w),
    .qv     (qv_b_w)
  );

  assign bus.q_a  = q_a_w;
  assign bus.q_b  = q_b_w;
  assign bus.qv_a = qv_a_w;
  assign bus.qv_b = qv_b_w;

endmodule : ram_dual_port_pipelined

// File: doc/ram_dual_port_pipelined.md
# ram_dual_port_pipelined

Generic true dual-port RAM with independent A/B ports, per-port byte enables, a read-valid pipeline of configurable depth, a working clock enable that stalls the whole block, and selectable mixed-port read-during-write behaviour. Vendor-neutral: memory is inferred, with no vendor primitive. Used by trace buffers and filter tables wherever reads need a valid flag and a latency that keeps matching under stalls.

## Interface
Parameters:
- WIDTH, 32, data width per word; must be a multiple of BYTE_W
- DEPTH, 256, number of words
- ADDR_W, $clog2(DEPTH), address width
- BYTE_W, 8, bits per byte-enable lane; NBE = WIDTH/BYTE_W
- LATENCY, 2, read latency in enabled cycles; legal range is ≥1
- RDW_MIXED, RDW_OLD, mixed-port read-during-write mode: RDW_OLD or RDW_NEW
- INIT_ZERO, 1, 1 = simulation/synthesis initial contents are all zero

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  the single clock
- rst  in  1  synchronous, active-high reset
- clken  in  1  global enable; 0 freezes every register and blocks writes
- addr_a / addr_b  in  ADDR_W  port address
- data_a / data_b  in  WIDTH  write data
- wren_a / wren_b  in  1  write request
- be_a / be_b  in  NBE  byte-lane enables for writes
- rden_a / rden_b  in  1  read request
- q_a / q_b  out  WIDTH  read data
- qv_a / qv_b  out  1  read data valid, 1-cycle pulse per read

## Operation
- Inputs are sampled only on rising clk with clken=1; an "enabled cycle" is one with clken=1 and rst=0.
- Write: when wren_x=1, lanes with be_x[i]=1 are updated; other lanes keep their value. be_x=0 leaves memory unchanged.
- Read: when rden_x=1, the read is issued. Read and write may both occur on one port in the same cycle.
- Same-port read-during-write: returns new data merged per lane, written lanes new and unwritten lanes old.
- Mixed-port read-during-write (port x reads the address port y writes):
  - RDW_OLD: the pre-write word.
  - RDW_NEW: y's data forwarded per y's enabled lanes.
- Dual write to the same address: port B wins on overlapping lanes; non-overlapping lanes of both ports are written.
- Out-of-range address (≥DEPTH): writes are ignored; reads return 0 with qv asserted.
- q_x holds its last valid value while qv_x=0.
- rst clears the valid pipeline, qv_a/qv_b and q_a/q_b to 0. Memory contents are not reset.

## Timing
- A read issued at enabled cycle t gives q_x valid and qv_x=1 after exactly LATENCY further enabled cycles. Cycles with clken=0 do not count.
- With LATENCY=1: array read register only. LATENCY>1 adds LATENCY-1 output stages, which carry data and valid together.
- Full throughput: one read per port per enabled cycle. No backpressure and no busy output.
- clken=0: q_x, qv_x and every pipeline stage hold their value. A qv pulse held across a stall stays high until the next enabled cycle.
- rst with clken=0 still resets. In-flight reads at reset are dropped and never produce qv.
- Reset values: q_a=q_b=0, qv_a=qv_b=0.

## Structure
- Package ram_pkg: typedef enum rdw_mode_e {RDW_OLD, RDW_NEW} and the function byte_merge(old, new, be).
- Sub-module ram_read_pipe (parameters WIDTH, LATENCY): shift register for data+valid with clken and rst. Instantiated once per port.
- Top module: the memory array, the write logic with byte merge and B-priority, and the forwarding mux.

## Test plan
- Write A addr 5 = 0xDEADBEEF, be=4'hF; read B addr 5 next cycle, LATENCY=2 -> qv_b pulse 2 cycles later, q_b=0xDEADBEEF.
- Same cycle: A writes addr 9 = 0x11223344 with be=4'b0011 over old 0xAABBCCDD, and B reads addr 9. RDW_OLD -> q_b=0xAABBCCDD; RDW_NEW -> q_b=0xAABB3344. A's same-port read -> 0xAABB3344.
- Both ports write addr 3, A=0x01010101 be=4'hF, B=0x02020202 be=4'b1100 -> readback 0x02020101.
- Read issued, then clken low for 3 cycles mid-pipeline (LATENCY=3) -> qv delayed by exactly 3 cycles; q and qv frozen during the stall.
- Back-to-back reads of addrs 0..7, rst asserted at the 4th cycle -> q=0 and qv=0 next cycle; no qv from reads issued before reset; memory contents intact on re-read.
- Read addr ≥DEPTH (DEPTH=200, addr 250) -> q=0 with qv=1; write to addr 250 does not alias addr 50.
